// File: rtl/mux_stream_nby1.sv
// N-to-1 stream mux with a registered output slot, fixed or round-robin selection.
// One word per cycle when the consumer keeps out_ready high; back-pressure stalls every input.

module mux_stream_nby1_lane #(
    parameter int SELW = 2,
    parameter int IDX  = 0
) (
    input  logic            load_ok,
    input  logic            grant_valid,
    input  logic [SELW-1:0] grant,
    output logic            ready
);
    assign ready = load_ok && grant_valid && (grant == SELW'(IDX));
endmodule

module mux_stream_nby1 #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SELW   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SELW-1:0]         sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SELW-1:0]         out_src
);
    logic [NUM_IN-1:0][WIDTH-1:0] chan;
    logic [SELW-1:0]              rr_ptr;
    logic [SELW-1:0]              grant;
    logic                         grant_valid;
    logic                         load_ok;
    logic                         xfer;
    int                           rr_idx;

    assign chan    = in_data;
    assign load_ok = rst_n && (!out_valid || out_ready);
    assign xfer    = load_ok && grant_valid;

    // Round-robin scans downward so the channel closest after rr_ptr is written last and wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        rr_idx      = 0;
        if (!mode) begin
            if (int'(sel) < NUM_IN && in_valid[sel]) begin
                grant       = sel;
                grant_valid = 1'b1;
            end
        end else begin
            for (int k = NUM_IN; k >= 1; k--) begin
                rr_idx = (int'(rr_ptr) + k) % NUM_IN;
                if (in_valid[rr_idx]) begin
                    grant       = SELW'(rr_idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        mux_stream_nby1_lane #(.SELW(SELW), .IDX(i)) u_lane (
            .load_ok     (load_ok),
            .grant_valid (grant_valid),
            .grant       (grant),
            .ready       (in_ready[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= SELW'(NUM_IN - 1);
        end else begin
            if (xfer) begin
                out_data  <= chan[grant];
                out_src   <= grant;
                out_valid <= 1'b1;
                if (mode) rr_ptr <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_stream_nby1.sv
// Scoreboard bench for mux_stream_nby1: a driver predicts grants from the selection rules,
// a monitor checks every word the DUT presents against the queue of accepted words.

module tb_mux_stream_nby1;
    localparam int W = 8;
    localparam int N = 4;
    localparam int S = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [S-1:0]   sel;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [S-1:0]   out_src;

    int tests = 0;
    int fails = 0;

    // Reference state: last channel served in round-robin, and whether the output slot is full.
    int last_rr = N - 1;
    bit occ = 1'b0;
    int acc_ch = -1;
    int q_src[$];
    int q_dat[$];

    always #5 clk = ~clk;

    mux_stream_nby1 #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int word(input int ch);
        return int'(in_data[ch*W +: W]);
    endfunction

    function automatic void set_word(input int ch, input int v);
        in_data[ch*W +: W] = W'(v);
    endfunction

    // Which channel the rules pick this cycle, or -1.
    function automatic int pick();
        if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
        for (int k = 1; k <= N; k++)
            if (in_valid[(last_rr + k) % N]) return (last_rr + k) % N;
        return -1;
    endfunction

    task automatic step();
        int g;
        bit x;
        int d;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        g = pick();
        x = rst_n && (!occ || out_ready) && (g >= 0);
        exp_rdy = '0;
        if (x) exp_rdy[g] = 1'b1;
        d = x ? word(g) : 0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        acc_ch = x ? g : -1;
        if (!rst_n) begin
            q_src.delete();
            q_dat.delete();
            last_rr = N - 1;
            occ = 1'b0;
        end else if (x) begin
            q_src.push_back(g);
            q_dat.push_back(d);
            occ = 1'b1;
            if (mode) last_rr = g;
        end else if (out_ready) begin
            occ = 1'b0;
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            chk("out_valid", 32'(out_valid), 32'(q_src.size() != 0));
            if (out_valid && q_src.size() != 0) begin
                chk("out_src", 32'(out_src), 32'(q_src[0]));
                chk("out_data", 32'(out_data), 32'(q_dat[0]));
                if (out_ready) begin
                    void'(q_src.pop_front());
                    void'(q_dat.pop_front());
                end
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0; in_valid = '1; out_ready = 1'b1; mode = 1'b1; sel = '0;
        for (int i = 0; i < N; i++) set_word(i, $urandom_range(255));

        // reset with every input offering
        steps(2);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_src", 32'(out_src), 0);
        rst_n = 1'b1; #1;
        chk("rr_first", 32'(in_ready), 32'b0001);
        steps(1);

        // fixed select, then an out-of-range-of-valid selection
        mode = 1'b0; sel = 2; set_word(2, 'hA5); #1;
        chk("fixed_rdy", 32'(in_ready), 32'b0100);
        steps(4);
        chk("fixed_data", 32'(out_data), 'hA5);
        chk("fixed_src", 32'(out_src), 2);
        sel = 3; in_valid = 4'b0111; #1;
        chk("nogrant_rdy", 32'(in_ready), 0);
        steps(3);
        chk("drained", 32'(out_valid), 0);

        // round-robin fairness, full and sparse
        mode = 1'b1; in_valid = '1;
        for (int i = 0; i < N; i++) set_word(i, 'h10 + i);
        steps(8);
        in_valid = 4'b1010;
        steps(4);

        // back-pressure
        mode = 1'b0; sel = 1; in_valid = '1; set_word(1, 'h3C);
        steps(1);
        out_ready = 1'b0; set_word(1, 'h55);
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_rdy", 32'(in_ready), 0);
            step();
            chk("bp_hold", 32'(out_data), 'h3C);
        end
        out_ready = 1'b1; #1;
        chk("bp_release", 32'(in_ready), 32'b0010);
        steps(2);

        // mode switch keeps the round-robin pointer
        rst_n = 1'b0; steps(1);
        rst_n = 1'b1; mode = 1'b1; in_valid = '1;
        steps(2);
        mode = 1'b0; sel = 0;
        steps(3);
        mode = 1'b1; #1;
        chk("rr_resume", 32'(in_ready), 32'b0100);
        steps(1);

        // reset while a word is stalled in the output slot
        mode = 1'b0; sel = 0; set_word(0, 'h77);
        steps(1);
        out_ready = 1'b0;
        steps(1);
        chk("stall_data", 32'(out_data), 'h77);
        rst_n = 1'b0;
        steps(1);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        rst_n = 1'b1; mode = 1'b1; in_valid = '1; out_ready = 1'b1; #1;
        chk("mid_rst_rr", 32'(in_ready), 32'b0001);
        steps(1);

        // random traffic; an offered word stays put until accepted
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!in_valid[i] || acc_ch == i) begin
                    in_valid[i] = ($urandom_range(3) != 0);
                    set_word(i, $urandom_range(255));
                end
            end
            out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) mode = ~mode;
            if ($urandom_range(7) == 0) sel = S'($urandom_range(N - 1));
            if ($urandom_range(499) == 0) rst_n = 1'b0; else rst_n = 1'b1;
            step();
        end
        rst_n = 1'b1; in_valid = '0; out_ready = 1'b1;
        steps(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux_stream_nby1.md
Name: mux_stream_nby1

Overview:
- Parametrised, registered successor to the combinational 8-bit 2:1 mux: selects one of NUM_IN WIDTH-bit input streams and presents it on a single registered output stream.
- Every input and the output use a valid/ready handshake.
- Two selection modes: fixed (external select) and round-robin arbitration across valid inputs.
- Sits between ALU operand/result producers and a shared consumer (e.g. result bus or register-file write port).

Parameters:
WIDTH, 8, data width per channel (>=1)
NUM_IN, 4, number of input channels (>=2)
SELW, $clog2(NUM_IN), select/source index width (derived; do not override)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NUM_IN  channel i offers a word
in_ready  output  NUM_IN  channel i word accepted this cycle (combinational)
mode  input  1  0 = fixed select via sel, 1 = round-robin
sel  input  SELW  channel index used when mode=0
out_data  output  WIDTH  registered selected word
out_valid  output  1  out_data holds a word
out_ready  input  1  consumer accepts out_data this cycle
out_src  output  SELW  index of the channel that produced out_data

Behaviour:
- Reset (rst_n=0 at a rising edge): out_valid=0, out_data=0, out_src=0, rr_ptr=NUM_IN-1, so channel 0 has first round-robin priority. Reset is synchronous only; a pending output word is discarded and no in_ready is asserted while rst_n=0.
- can_load = !out_valid || out_ready. This gives full throughput: one word per cycle when out_ready is held high.
- Grant, combinational, evaluated every cycle:
  - mode=0: grant channel sel if sel<NUM_IN and in_valid[sel]. sel>=NUM_IN means no grant (out-of-range is never an error).
  - mode=1: grant the first channel with in_valid set, searching rr_ptr+1, rr_ptr+2, … modulo NUM_IN. If no in_valid bit is set, there is no grant.
- in_ready[i] = rst_n && can_load && grant_valid && grant==i. At most one in_ready bit is high per cycle (one-hot or zero).
- Transfer on channel i when in_valid[i] && in_ready[i]. At the next edge: out_data <= word i, out_src <= i, out_valid <= 1.
- Output drains when out_valid && out_ready with no transfer. At the next edge out_valid <= 0; out_data and out_src hold their last values.
- Simultaneous drain and load in the same cycle replaces the word with no bubble.
- out_valid=1 && out_ready=0: out_data, out_src and out_valid are held stable, and all in_ready bits are 0 (backpressure).
- rr_ptr update: rr_ptr <= granted index only on a transfer in mode=1. Fixed-mode transfers do not move rr_ptr. Changing mode does not reset rr_ptr.
- mode and sel are sampled combinationally in the cycle of grant. Changing them affects only the next transfer, never a word already in the output register.
- Latency: input transfer to out_valid is 1 cycle.
- Inputs are assumed to hold in_valid/in_data stable until accepted. The block does not check this.

Test Plan:
1. Reset: hold rst_n=0 with all in_valid=1 and out_ready=1 -> in_ready=0000, out_valid=0, out_data=0x00, out_src=0. Release, and next cycle in_ready=0001 (mode=1).
2. Fixed mode: mode=0, sel=2, in_data ch2=0xA5, all in_valid=1, out_ready=1 -> in_ready=0100 every cycle; out_data=0xA5, out_src=2 one cycle later. sel=3 with in_valid=0111 -> no grant, out_valid drops to 0 after drain.
3. Round-robin fairness: mode=1, all in_valid=1 held, channel data 0x10/0x11/0x12/0x13, out_ready=1 -> out_src sequence 0,1,2,3,0,… with back-to-back out_valid=1. With only in_valid=1010 -> 1,3,1,3.
4. Backpressure: out_valid=1, out_data=0x3C, out_ready=0 for 5 cycles with inputs valid -> in_ready=0000 and out_data stays 0x3C. On out_ready=1, the next word loads in the same cycle the old one drains.
5. Mode switch: run mode=1 to rr_ptr=1, switch to mode=0 sel=0 for 3 transfers, return to mode=1 with all valid -> next grant is channel 2 (rr_ptr unchanged by fixed mode).
6. Mid-operation reset: out_valid=1, out_data=0x77, out_ready=0; assert rst_n=0 for 1 cycle -> out_valid=0, out_data=0x00, rr_ptr restored so the first RR grant after release is channel 0.
